// File: rtl/mac_completion_status_if.sv
// Event and result signals exchanged between the MAC traffic test harness
// (generator/monitor side) and the completion status controller.
interface mac_completion_status_if;
    logic        restart_tx_rx;
    logic        rx_block_lock;
    logic        tx_pkt_done;
    logic [13:0] tx_pkt_len;
    logic        rx_pkt_done;
    logic [13:0] rx_pkt_len;
    logic        rx_prot_err;
    logic        rx_bit_err;
    logic        tx_start;
    logic [4:0]  completion_status;

    modport master (
        output restart_tx_rx, rx_block_lock, tx_pkt_done, tx_pkt_len,
               rx_pkt_done, rx_pkt_len, rx_prot_err, rx_bit_err,
        input  tx_start, completion_status
    );

    modport slave (
        input  restart_tx_rx, rx_block_lock, tx_pkt_done, tx_pkt_len,
               rx_pkt_done, rx_pkt_len, rx_prot_err, rx_bit_err,
        output tx_start, completion_status
    );
endinterface

// File: rtl/mac_completion_status.sv
// Sequences a MAC loopback traffic test: waits for rx block lock, lets the
// generator send NUM_PKTS packets, drains the receiver, then grades the run.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | just out of reset, moves to WAIT_LOCK on the first edge
// WAIT_LOCK | waiting for rx_block_lock, bounded by LOCK_TIMEOUT
// TX        | tx_start high, counting tx/rx packets, bounded by TX_TIMEOUT
// DRAIN     | tx finished, waiting for rx to catch up (DRAIN_CYCLES)
// CHECK     | one cycle, latches the highest-priority result code
// DONE      | holds completion_status until restart
module mac_completion_status #(
    parameter int NUM_PKTS     = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int TX_TIMEOUT   = 1048576,
    parameter int DRAIN_CYCLES = 1024
) (
    input  logic                  dclk,
    input  logic                  sys_reset_n,
    mac_completion_status_if.slave mac
);

    typedef enum logic [2:0] {IDLE, WAIT_LOCK, TX, DRAIN, CHECK, DONE} state_t;

    localparam logic [15:0] NUM_W    = 16'(NUM_PKTS);
    localparam logic [31:0] LOCK_TC  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] TX_TC    = 32'(TX_TIMEOUT - 1);
    localparam logic [31:0] DRAIN_TC = 32'(DRAIN_CYCLES - 1);

    localparam logic [4:0] ST_BUSY    = 5'h1F;
    localparam logic [4:0] ST_PASS    = 5'h01;
    localparam logic [4:0] ST_NO_LOCK = 5'h02;
    localparam logic [4:0] ST_LOST    = 5'h04;
    localparam logic [4:0] ST_TX_TO   = 5'h0A;
    localparam logic [4:0] ST_NO_TX   = 5'h0B;
    localparam logic [4:0] ST_PKT_MIS = 5'h0C;
    localparam logic [4:0] ST_BYT_MIS = 5'h0D;
    localparam logic [4:0] ST_PROT    = 5'h0E;
    localparam logic [4:0] ST_BIT     = 5'h0F;

    state_t      state, state_nxt;
    logic [31:0] timer, timer_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt, rx_cnt, rx_cnt_nxt;
    logic [31:0] tx_bytes, tx_bytes_nxt, rx_bytes, rx_bytes_nxt;
    logic        lost_lock, lost_lock_nxt;
    logic        prot_err, prot_err_nxt;
    logic        bit_err, bit_err_nxt;
    logic        tx_to, tx_to_nxt;
    logic        no_tx, no_tx_nxt;
    logic [4:0]  status_nxt;
    logic        tx_start_nxt;
    logic [4:0]  check_code;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [13:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {19'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Grade the run: sticky error flags first, then count/byte comparisons.
    // A saturated counter can no longer prove equality, so it counts as a mismatch.
    always_comb begin
        check_code = ST_PASS;
        if (lost_lock)
            check_code = ST_LOST;
        else if (prot_err)
            check_code = ST_PROT;
        else if (bit_err)
            check_code = ST_BIT;
        else if (tx_to)
            check_code = ST_TX_TO;
        else if (no_tx)
            check_code = ST_NO_TX;
        else if ((rx_cnt != tx_cnt) || (&rx_cnt) || (&tx_cnt))
            check_code = ST_PKT_MIS;
        else if ((rx_bytes != tx_bytes) || (&rx_bytes) || (&tx_bytes))
            check_code = ST_BYT_MIS;
    end

    // Next-state, counters, flags and status; restart overrides everything.
    always_comb begin
        state_nxt     = state;
        tx_cnt_nxt    = tx_cnt;
        rx_cnt_nxt    = rx_cnt;
        tx_bytes_nxt  = tx_bytes;
        rx_bytes_nxt  = rx_bytes;
        lost_lock_nxt = lost_lock;
        prot_err_nxt  = prot_err;
        bit_err_nxt   = bit_err;
        tx_to_nxt     = tx_to;
        no_tx_nxt     = no_tx;
        status_nxt    = mac.completion_status;
        timer_nxt     = '0;

        if (state == TX && mac.tx_pkt_done) begin
            tx_cnt_nxt   = sat_inc16(tx_cnt);
            tx_bytes_nxt = sat_add32(tx_bytes, mac.tx_pkt_len);
        end
        if (state == TX || state == DRAIN) begin
            if (mac.rx_pkt_done) begin
                rx_cnt_nxt   = sat_inc16(rx_cnt);
                rx_bytes_nxt = sat_add32(rx_bytes, mac.rx_pkt_len);
            end
            if (mac.rx_prot_err)
                prot_err_nxt = 1'b1;
            if (mac.rx_bit_err)
                bit_err_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                state_nxt  = WAIT_LOCK;
                status_nxt = ST_BUSY;
            end
            WAIT_LOCK: begin
                if (mac.rx_block_lock) begin
                    state_nxt = TX;
                end else if (timer == LOCK_TC) begin
                    state_nxt  = DONE;
                    status_nxt = ST_NO_LOCK;
                end
            end
            TX: begin
                if (!mac.rx_block_lock) begin
                    lost_lock_nxt = 1'b1;
                    state_nxt     = CHECK;
                end else if (tx_cnt_nxt == NUM_W) begin
                    state_nxt = DRAIN;
                end else if (timer == TX_TC) begin
                    if (tx_cnt_nxt == 16'd0)
                        no_tx_nxt = 1'b1;
                    else
                        tx_to_nxt = 1'b1;
                    state_nxt = CHECK;
                end
            end
            DRAIN: begin
                if (!mac.rx_block_lock) begin
                    lost_lock_nxt = 1'b1;
                    state_nxt     = CHECK;
                end else if (rx_cnt == tx_cnt || timer == DRAIN_TC) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                status_nxt = check_code;
                state_nxt  = DONE;
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        if (mac.restart_tx_rx) begin
            state_nxt     = WAIT_LOCK;
            tx_cnt_nxt    = '0;
            rx_cnt_nxt    = '0;
            tx_bytes_nxt  = '0;
            rx_bytes_nxt  = '0;
            lost_lock_nxt = 1'b0;
            prot_err_nxt  = 1'b0;
            bit_err_nxt   = 1'b0;
            tx_to_nxt     = 1'b0;
            no_tx_nxt     = 1'b0;
            status_nxt    = ST_BUSY;
        end else if (state_nxt == state &&
                     (state == WAIT_LOCK || state == TX || state == DRAIN)) begin
            timer_nxt = timer + 32'd1;
        end

        tx_start_nxt = (state_nxt == TX);
    end

    // Register all controller state; reset clears everything asynchronously.
    always_ff @(posedge dclk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state                 <= IDLE;
            timer                 <= '0;
            tx_cnt                <= '0;
            rx_cnt                <= '0;
            tx_bytes              <= '0;
            rx_bytes              <= '0;
            lost_lock             <= 1'b0;
            prot_err              <= 1'b0;
            bit_err               <= 1'b0;
            tx_to                 <= 1'b0;
            no_tx                 <= 1'b0;
            mac.completion_status <= 5'h00;
            mac.tx_start          <= 1'b0;
        end else begin
            state                 <= state_nxt;
            timer                 <= timer_nxt;
            tx_cnt                <= tx_cnt_nxt;
            rx_cnt                <= rx_cnt_nxt;
            tx_bytes              <= tx_bytes_nxt;
            rx_bytes              <= rx_bytes_nxt;
            lost_lock             <= lost_lock_nxt;
            prot_err              <= prot_err_nxt;
            bit_err               <= bit_err_nxt;
            tx_to                 <= tx_to_nxt;
            no_tx                 <= no_tx_nxt;
            mac.completion_status <= status_nxt;
            mac.tx_start          <= tx_start_nxt;
        end
    end

endmodule

// File: tb/tb_mac_completion_status.sv
// Directed bench for mac_completion_status with shortened timeouts.
module tb_mac_completion_status;

    localparam int NUM_PKTS     = 16;
    localparam int LOCK_TIMEOUT = 1000;
    localparam int TX_TIMEOUT   = 500;
    localparam int DRAIN_CYCLES = 100;

    logic dclk;
    logic sys_reset_n;
    int   checks   = 0;
    int   failures = 0;

    mac_completion_status_if mac_if();

    mac_completion_status #(
        .NUM_PKTS     (NUM_PKTS),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .TX_TIMEOUT   (TX_TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .dclk        (dclk),
        .sys_reset_n (sys_reset_n),
        .mac         (mac_if)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Absolute time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic clear_inputs();
        mac_if.restart_tx_rx = 1'b0;
        mac_if.rx_block_lock = 1'b0;
        mac_if.tx_pkt_done   = 1'b0;
        mac_if.tx_pkt_len    = 14'd64;
        mac_if.rx_pkt_done   = 1'b0;
        mac_if.rx_pkt_len    = 14'd64;
        mac_if.rx_prot_err   = 1'b0;
        mac_if.rx_bit_err    = 1'b0;
    endtask

    // Reset, release, and land one edge later in WAIT_LOCK.
    task automatic reset_dut();
        sys_reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge dclk);
        #1;
        check_val("rst_status", {27'd0, mac_if.completion_status}, 32'h00);
        check_val("rst_tx_start", {31'd0, mac_if.tx_start}, 32'd0);
        sys_reset_n = 1'b1;
        tick();
        check_val("wait_lock_status", {27'd0, mac_if.completion_status}, 32'h1F);
    endtask

    task automatic enter_tx(input int delay);
        repeat (delay) tick();
        mac_if.rx_block_lock = 1'b1;
        tick();
        check_val("tx_start_on", {31'd0, mac_if.tx_start}, 32'd1);
    endtask

    // tx packet i pulses at cycle 20*i, rx packet i at 20*i+10.
    task automatic run_traffic(input int n_tx, input int n_rx, input int short_idx, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            mac_if.tx_pkt_done = ((c % 20) == 0) && ((c / 20) < n_tx);
            mac_if.rx_pkt_done = (c >= 10) && (((c - 10) % 20) == 0) && (((c - 10) / 20) < n_rx);
            mac_if.rx_pkt_len  = (c >= 10 && ((c - 10) / 20) == short_idx) ? 14'd60 : 14'd64;
            tick();
            if (c == 0 && n_tx > 1)
                check_val("tx_start_hold", {31'd0, mac_if.tx_start}, 32'd1);
            if (n_tx == NUM_PKTS && c == 20 * (n_tx - 1)) begin
                check_val("tx_start_drop", {31'd0, mac_if.tx_start}, 32'd0);
                check_val("drain_busy", {27'd0, mac_if.completion_status}, 32'h1F);
            end
        end
        mac_if.tx_pkt_done = 1'b0;
        mac_if.rx_pkt_done = 1'b0;
        mac_if.rx_pkt_len  = 14'd64;
    endtask

    initial begin
        int seen;
        sys_reset_n = 1'b0;
        clear_inputs();

        // Normal pass.
        reset_dut();
        enter_tx(49);
        run_traffic(16, 16, -1, 330);
        check_val("pass_status", {27'd0, mac_if.completion_status}, 32'h01);
        check_val("pass_tx_start", {31'd0, mac_if.tx_start}, 32'd0);

        // Restart held in DONE: stays in WAIT_LOCK with lock present.
        mac_if.restart_tx_rx = 1'b1;
        repeat (3) tick();
        check_val("rs_hold_status", {27'd0, mac_if.completion_status}, 32'h1F);
        check_val("rs_hold_tx_start", {31'd0, mac_if.tx_start}, 32'd0);
        check_val("rs_hold_timer", dut.timer, 32'd0);
        check_val("rs_tx_cnt", {16'd0, dut.tx_cnt}, 32'd0);
        mac_if.restart_tx_rx = 1'b0;
        tick();
        check_val("rs_tx_start", {31'd0, mac_if.tx_start}, 32'd1);

        // Restart mid-TX together with packet pulses: pulses not counted.
        run_traffic(5, 5, -1, 100);
        mac_if.restart_tx_rx = 1'b1;
        mac_if.tx_pkt_done   = 1'b1;
        mac_if.rx_pkt_done   = 1'b1;
        tick();
        mac_if.restart_tx_rx = 1'b0;
        mac_if.tx_pkt_done   = 1'b0;
        mac_if.rx_pkt_done   = 1'b0;
        check_val("rs_mid_status", {27'd0, mac_if.completion_status}, 32'h1F);
        check_val("rs_mid_tx_start", {31'd0, mac_if.tx_start}, 32'd0);
        check_val("rs_mid_tx_cnt", {16'd0, dut.tx_cnt}, 32'd0);
        check_val("rs_mid_rx_cnt", {16'd0, dut.rx_cnt}, 32'd0);
        tick();
        check_val("rs_mid_retx", {31'd0, mac_if.tx_start}, 32'd1);
        run_traffic(16, 16, -1, 330);
        check_val("rs_pass_status", {27'd0, mac_if.completion_status}, 32'h01);

        // Lock never arrives: 0x02 exactly LOCK_TIMEOUT cycles after WAIT_LOCK.
        reset_dut();
        seen = 0;
        for (int i = 0; i < LOCK_TIMEOUT - 1; i++) begin
            tick();
            if (mac_if.tx_start) seen++;
        end
        check_val("no_lock_busy", {27'd0, mac_if.completion_status}, 32'h1F);
        tick();
        check_val("no_lock_status", {27'd0, mac_if.completion_status}, 32'h02);
        check_val("no_lock_tx_start", seen, 32'd0);

        // 16 sent, 15 received: drain times out, then 0x0C.
        reset_dut();
        enter_tx(0);
        run_traffic(16, 15, -1, 401);
        check_val("drain_to_busy", {27'd0, mac_if.completion_status}, 32'h1F);
        tick();
        check_val("pkt_mis_status", {27'd0, mac_if.completion_status}, 32'h0C);

        // One short rx packet: byte mismatch.
        reset_dut();
        enter_tx(0);
        run_traffic(16, 16, 5, 330);
        check_val("byte_mis_status", {27'd0, mac_if.completion_status}, 32'h0D);

        // Lock drops together with a bit error: lost lock wins, two edges later.
        reset_dut();
        enter_tx(0);
        run_traffic(2, 2, -1, 40);
        mac_if.rx_block_lock = 1'b0;
        mac_if.rx_bit_err    = 1'b1;
        tick();
        mac_if.rx_bit_err = 1'b0;
        check_val("lost_tx_start", {31'd0, mac_if.tx_start}, 32'd0);
        tick();
        check_val("lost_status", {27'd0, mac_if.completion_status}, 32'h04);

        // Silent generator: no tx data, exact TX timeout edge.
        reset_dut();
        enter_tx(0);
        repeat (TX_TIMEOUT - 1) tick();
        check_val("no_tx_still_tx", {31'd0, mac_if.tx_start}, 32'd1);
        tick();
        check_val("no_tx_drop", {31'd0, mac_if.tx_start}, 32'd0);
        tick();
        check_val("no_tx_status", {27'd0, mac_if.completion_status}, 32'h0B);

        // Three packets then silence: tx timeout.
        reset_dut();
        enter_tx(0);
        run_traffic(3, 3, -1, 70);
        repeat (440) tick();
        check_val("tx_to_status", {27'd0, mac_if.completion_status}, 32'h0A);

        // Asynchronous reset mid-TX clears outputs without a clock edge.
        reset_dut();
        enter_tx(0);
        run_traffic(2, 2, -1, 40);
        #3;
        sys_reset_n = 1'b0;
        #1;
        check_val("async_rst_status", {27'd0, mac_if.completion_status}, 32'h00);
        check_val("async_rst_tx_start", {31'd0, mac_if.tx_start}, 32'd0);

        // Simultaneous protocol and bit errors plus timeout: 0x0E wins.
        reset_dut();
        enter_tx(0);
        run_traffic(2, 2, -1, 40);
        mac_if.rx_prot_err = 1'b1;
        mac_if.rx_bit_err  = 1'b1;
        tick();
        mac_if.rx_prot_err = 1'b0;
        mac_if.rx_bit_err  = 1'b0;
        check_val("both_err_flags", {30'd0, dut.prot_err, dut.bit_err}, 32'd3);
        repeat (480) tick();
        check_val("prot_status", {27'd0, mac_if.completion_status}, 32'h0E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
